// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants, state encoding and operation decode helpers for mdu_iter
package mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    // Operand A is treated as signed for mulh, mulhsu, div and rem.
    function automatic logic md_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/md_addsub33.sv
// rtl/md_addsub33.sv - 33-bit adder/subtractor shared by the multiply and divide iterations
module md_addsub33 #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] w_b_eff;

    assign w_b_eff = i_b ^ {W{i_sub}};
    assign o_sum   = i_a + w_b_eff + {{(W-1){1'b0}}, i_sub};

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// MDU_FAST_SPECIAL_EN: resolve divide-by-zero, signed overflow and multiply-by-zero at start.
module mdu_iter #(
    parameter int XLEN  = mdu_pkg::XLEN,
    parameter int CNT_W = mdu_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      MDCode,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] MDResult
);

    import mdu_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        r_state;
    logic [2:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opa;
    logic [XLEN-1:0]   r_opb;
    logic              r_neg;
    logic              r_div0;
    logic [XLEN-1:0]   r_res;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_mdresult;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_neg_in;
    logic              w_div0_in;

    logic              w_op_div;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_shrem;
    logic [XLEN:0]     w_add_a;
    logic [XLEN:0]     w_add_b;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_mul_hi;
    logic              w_qbit;
    logic [XLEN-1:0]   w_rem_next;
    logic [2*XLEN-1:0] w_acc_next;
    logic [XLEN-1:0]   w_opa_next;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    assign w_a_neg   = md_signed_a(MDCode) & A[XLEN-1];
    assign w_b_neg   = md_signed_b(MDCode) & B[XLEN-1];
    assign w_abs_a   = w_a_neg ? -A : A;
    assign w_abs_b   = w_b_neg ? -B : B;
    assign w_neg_in  = (MDCode == MD_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div0_in = md_is_div(MDCode) && (B == '0);

`ifdef MDU_FAST_SPECIAL_EN
    logic            w_ovf_in;
    logic            w_mz_in;
    logic            w_fast_hit;
    logic [XLEN-1:0] w_fast_res;

    assign w_ovf_in   = ((MDCode == MD_DIV) || (MDCode == MD_REM)) && (A == INT_MIN) && (B == '1);
    assign w_mz_in    = !md_is_div(MDCode) && ((A == '0) || (B == '0));
    assign w_fast_hit = w_div0_in || w_ovf_in || w_mz_in;

    always_comb begin
        w_fast_res = '0;
        if (w_div0_in) begin
            w_fast_res = MDCode[1] ? A : '1;
        end else if (w_ovf_in) begin
            w_fast_res = MDCode[1] ? '0 : INT_MIN;
        end
    end
`endif

    // Multiply: {hi,lo} accumulates the product, multiplier bits leave r_opa from the bottom.
    // Divide: {hi,lo} is {remainder,quotient}, dividend bits enter from the top of r_opa.
    assign w_op_div = md_is_div(r_op);
    assign w_hi     = r_acc[2*XLEN-1:XLEN];
    assign w_lo     = r_acc[XLEN-1:0];
    assign w_shrem  = {w_hi, r_opa[XLEN-1]};
    assign w_add_a  = w_op_div ? w_shrem : {1'b0, w_hi};
    assign w_add_b  = {1'b0, r_opb};

    md_addsub33 #(
        .W(XLEN + 1)
    ) u_addsub (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_sub (w_op_div),
        .o_sum (w_sum)
    );

    assign w_mul_hi   = r_opa[0] ? w_sum : {1'b0, w_hi};
    assign w_qbit     = ~w_sum[XLEN];
    assign w_rem_next = w_qbit ? w_sum[XLEN-1:0] : w_shrem[XLEN-1:0];

    always_comb begin
        w_acc_next = {w_mul_hi, w_lo[XLEN-1:1]};
        w_opa_next = {1'b0, r_opa[XLEN-1:1]};
        if (w_op_div) begin
            w_acc_next = {w_rem_next, w_lo[XLEN-2:0], w_qbit};
            w_opa_next = {r_opa[XLEN-2:0], 1'b0};
        end
    end

    // Divide by zero leaves an all-ones quotient and rem = |A|; only the signed quotient needs forcing.
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quot = r_div0 ? '1 : (r_neg ? -w_lo : w_lo);
    assign w_rem  = r_neg ? -w_hi : w_hi;

    always_comb begin
        w_fix_res = '0;
        case (r_op)
            MD_MUL:                        w_fix_res = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               w_fix_res = w_quot;
            default:                       w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= MD_MUL;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_neg      <= 1'b0;
            r_div0     <= 1'b0;
            r_res      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mdresult <= '0;
        end else if (kill) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= MDCode;
                        r_neg   <= w_neg_in;
                        r_div0  <= w_div0_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_opa   <= w_abs_a;
                        r_opb   <= w_abs_b;
                        r_busy  <= 1'b1;
                        r_state <= ST_CALC;
`ifdef MDU_FAST_SPECIAL_EN
                        if (w_fast_hit) begin
                            r_res   <= w_fast_res;
                            r_state <= ST_DONE;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_opa <= w_opa_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_res   <= w_fix_res;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result, second retires busy.
                    if (!r_done) begin
                        r_done     <= 1'b1;
                        r_mdresult <= r_res;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign MDResult = r_mdresult;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter
module tb_mdu_iter;

    import mdu_pkg::*;

`ifdef MDU_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  MDCode;
    logic [31:0] A;
    logic [31:0] B;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] MDResult;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] prev_exp = 32'h0;

    mdu_iter #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .MDCode   (MDCode),
        .A        (A),
        .B        (B),
        .kill     (kill),
        .busy     (busy),
        .done     (done),
        .MDResult (MDResult)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation and checks result, latency and busy; inject_at >= 0 pulses a
    // stray start (mul 3*5) that many cycles into the operation.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                         input int inject_at);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; MDCode = op; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_rise"}, {31'b0, busy}, 32'd1);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 60) begin
            if (lat == inject_at) begin
                start = 1'b1; MDCode = MD_MUL; A = 32'd3; B = 32'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, MDResult, exp_res);
        check({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_busy_fall"}, {31'b0, busy}, 32'd0);
        check({tag, "_result_hold"}, MDResult, exp_res);
        prev_exp = exp_res;
    endtask

    initial begin : stim
        logic done_seen;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; MDCode = MD_MUL; A = '0; B = '0;
        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", MDResult, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mul_7_m6",     MD_MUL,    32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, 34, -1);
        do_op("mulh_min",     MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, -1);
        do_op("mulhsu_min",   MD_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 34, -1);
        do_op("mulhu_min",    MD_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 34, -1);
        do_op("mulh_m1_2",    MD_MULH,   32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, -1);
        do_op("div_m7_2",     MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, -1);
        do_op("rem_m7_2",     MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, -1);
        do_op("div_m7_m2",    MD_DIV,    32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        34, -1);
        do_op("divu_100_7",   MD_DIVU,   32'd100,      32'd7,        32'd14,       34, -1);
        do_op("remu_100_7",   MD_REMU,   32'd100,      32'd7,        32'd2,        34, -1);
        do_op("div_by0",      MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT, -1);
        do_op("rem_by0",      MD_REM,    32'd5,        32'd0,        32'd5,        SPEC_LAT, -1);
        do_op("divu_by0",     MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPEC_LAT, -1);
        do_op("remu_by0",     MD_REMU,   32'd5,        32'd0,        32'd5,        SPEC_LAT, -1);
        do_op("div_ovf",      MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT, -1);
        do_op("rem_ovf",      MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPEC_LAT, -1);
        do_op("mul_by0",      MD_MUL,    32'd0,        32'd5,        32'd0,        SPEC_LAT, -1);

        // Kill at counter = 10: drop busy next cycle, no done, result untouched.
        @(negedge clk);
        start = 1'b1; MDCode = MD_DIVU; A = 32'd100; B = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", {31'b0, busy}, 32'd0);
        check("kill_done", {31'b0, done}, 32'd0);
        check("kill_result", MDResult, prev_exp);
        done_seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check("kill_no_done", {31'b0, done_seen}, 32'd0);

        // Kill wins over start in IDLE.
        @(negedge clk);
        start = 1'b1; kill = 1'b1; MDCode = MD_MUL; A = 32'd3; B = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("kill_start_idle", {31'b0, busy}, 32'd0);

        do_op("remu_ignore_start", MD_REMU, 32'd100, 32'd7, 32'd2, 34, 5);

        // Asynchronous reset mid-CALC, applied off the clock edge.
        @(negedge clk);
        start = 1'b1; MDCode = MD_MULHU; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_done", {31'b0, done}, 32'd0);
        check("arst_result", MDResult, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("mul_3_5", MD_MUL, 32'd3, 32'd5, 32'd15, 34, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit for the execute stage, next to the single-cycle ALU. It takes one operation from the decode/issue side over a start/busy/done handshake and returns the 32-bit result after a fixed multi-cycle latency. Multiplies use radix-2 shift-add and divides use restoring division, so one 33-bit add/subtract path is shared by both. The pipeline stalls the execute stage while `busy` is high.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `CNT_W`, default 5: width of the iteration counter (log2 of XLEN).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `MDCode`  in  3  operation, equal to RV32M funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `A`, `B`  in  32  rs1 and rs2 operands; sampled with `start`.
- `kill`  in  1  pipeline flush; aborts any operation.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse; `MDResult` is valid in that cycle.
- `MDResult`  out  32  result; held until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE to CALC: on `start`.
  - Latch `MDCode`.
  - Take absolute values of the signed operands: both for mulh/div/rem, A only for mulhsu, neither for mulhu/divu/remu/mul.
  - Record the result sign. For multiplies it is the XOR of the operand signs. For div it is the XOR of the signs; for rem it is the sign of A.
  - Clear the 64-bit accumulator and set counter = 0.
- CALC: one iteration per cycle for exactly 32 cycles (counter 0..31), then go to FIX.
  - Multiply: if multiplier bit0 = 1, add the multiplicand to the upper accumulator half (33-bit add). Then shift the {carry, acc} pair right by 1.
  - Divide: shift {rem, quot} left by 1. Trial-subtract the divisor from rem (33-bit). If the result is non-negative, keep it and set quot bit0 = 1.
- FIX: apply two's-complement negation if the recorded sign requires it (64-bit for multiply), then go to DONE.
  - mul returns the low 32 bits; mulh/mulhsu/mulhu return the high 32 bits.
  - div returns the quotient; rem returns the remainder.
- DONE: `done` = 1 for one cycle, then return to IDLE.
- Special cases (results are mandatory in every configuration):
  - Divide by zero: div/divu return 0xFFFFFFFF; rem/remu return A.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF): div returns 0x80000000; rem returns 0.
- `start` while `busy`: ignored, with no side effects.
- `kill` in any state: next state is IDLE, `busy` drops, no `done`, and `MDResult` keeps its previous value. If `kill` and `start` are both high in IDLE, `kill` wins and nothing is accepted.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `MDResult` 0, counter 0.
- Reset during operation clears everything immediately, asynchronously.
- `start` is sampled at edge E0. `busy` goes high after E0. CALC covers edges E1 to E32, FIX is E33, and `done` plus `MDResult` are valid in the cycle after E34. `busy` falls after E35.
- Latency from `start` to `done` is 34 cycles.
- Back-to-back: `start` may be reasserted in the first IDLE cycle after `done`.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `MDU_FAST_SPECIAL_EN` defined:
  - Divide by zero and signed overflow are detected at the IDLE-to-CALC transition.
  - The FSM jumps directly to DONE with the fixed result, so `done` comes 1 cycle after `start` is sampled.
  - Multiply by zero is also short-circuited this way, returning 0.
- Undefined:
  - Every operation takes the full 34 cycles.
  - Special-case results must still match the Operation section, with the correction applied in FIX.

## Structure
- `mdu_pkg` holds:
  - `MDCode` encodings as named constants (MD_MUL … MD_REMU).
  - The state encoding (2 bits) and XLEN.
- One sub-module: `md_addsub33`, a 33-bit add/subtract with a sub control. It is instantiated once and shared by the multiply and divide datapaths.
- The FSM, counter and operand/accumulator registers stay in `mdu_iter`.

## Test plan
- mul, A = 7, B = 0xFFFFFFFA (−6) → `MDResult` 0xFFFFFFD6; `done` exactly 34 cycles after `start`; `busy` high throughout.
- mulh / mulhsu / mulhu with A = B = 0x80000000 → 0x40000000 / 0xC0000000 / 0x40000000.
- div and rem, A = 0xFFFFFFF9 (−7), B = 2 → 0xFFFFFFFD and 0xFFFFFFFF; divu, A = 100, B = 7 → 14; remu → 2.
- div by 0 with A = 5 → 0xFFFFFFFF; rem → 5; div 0x80000000 / 0xFFFFFFFF → 0x80000000 and rem → 0. Latency is 1 cycle with `MDU_FAST_SPECIAL_EN` and 34 without.
- Assert `kill` at CALC counter = 10 → IDLE next cycle, no `done`, `MDResult` unchanged. Then assert `start` while `busy` during a second operation → that `start` is ignored and the result matches the first request.
- Assert `rst_n` low mid-CALC, off the clock edge → `busy`/`done`/`MDResult` go to 0 immediately; after release, a new mul 3 × 5 → 15.
